rotator_scheduler: RTL and testbench
====================================

ROTATOR_SCHEDULER -- requirements
Module: rotator_scheduler

Interface
REQ-001 Parameter G_DWIDTH, default 24, sample width of each I/Q component.
REQ-002 Parameter G_NUM_CH, default 4, number of requesting channels (legal 2..8).
REQ-003 Parameter G_CH_BITS, default $clog2(G_NUM_CH), channel-index width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 enable  input  1  synchronous run enable; 0 = flush.
REQ-007 phase_clr  input  G_NUM_CH  per-channel phase-counter clear, one bit per channel.
REQ-008 ch_re, ch_im  input  G_NUM_CH*G_DWIDTH  packed channel samples, channel i at bits [i*G_DWIDTH +: G_DWIDTH].
REQ-009 ch_valid  input  G_NUM_CH / ch_ready  output  G_NUM_CH  per-channel input handshake.
REQ-010 rot_re, rot_im  output  G_DWIDTH  sample issued to shared rotator.
REQ-011 rot_phase  output  2  quarter-turn index issued with the sample (0..3).
REQ-012 rot_valid  output  1 / rot_ready  input  1  rotator issue handshake.
REQ-013 res_re, res_im  input  G_DWIDTH / res_valid  input  1 / res_ready  output  1  rotator result handshake.
REQ-014 dout_re, dout_im  output  G_DWIDTH / dout_ch  output  G_CH_BITS / dout_valid  output  1 / dout_ready  input  1  tagged result output.

Function
REQ-015 States SHALL be SM_ARB, SM_ISSUE, SM_WAIT, SM_SEND; exactly one transaction in flight.
REQ-016 SM_ARB: ch_ready SHALL be one-hot on the round-robin winner among asserted ch_valid, searching from last_grant+1 upward with wrap; ch_ready all-zero when no ch_valid.
REQ-017 ch_ready SHALL be zero in every state other than SM_ARB; transfer occurs on ch_valid[i] & ch_ready[i].
REQ-018 On transfer: capture channel data, grant index, and phase_cnt[grant]; increment phase_cnt[grant] modulo 4 (3 wraps to 0); go SM_ISSUE.
REQ-019 SM_ISSUE: rot_valid=1, rot_re/rot_im/rot_phase held stable from capture; on rot_ready go SM_WAIT.
REQ-020 SM_WAIT: res_ready=1; on res_valid capture res_re/res_im, go SM_SEND.
REQ-021 SM_SEND: dout_valid=1, dout_ch=grant, data stable; on dout_ready update last_grant=grant, go SM_ARB.
REQ-022 res_valid outside SM_WAIT SHALL be ignored (res_ready=0).
REQ-023 Minimum latency: transfer in cycle N -> rot_valid N+1 -> dout_valid N+3 when rot_ready and res_valid are high on first opportunity; throughput one sample per 4 cycles max.
REQ-024 phase_clr[i]=1 SHALL set phase_cnt[i]=0 next cycle; coincident with transfer on channel i, captured phase uses the pre-clear value and counter ends at 0 (clear wins over increment).
REQ-025 Phase counters of non-granted channels SHALL not change except by phase_clr.
REQ-026 enable=0 SHALL synchronously force SM_ARB, clear all phase_cnt, set last_grant=G_NUM_CH-1, and hold ch_ready, rot_valid, res_ready, dout_valid at 0 while low; in-flight transaction is discarded.
REQ-027 Data outputs are don't-care when their valid is low; no combinational path from rot_ready, res_valid or dout_ready to any output.

Reset
REQ-028 reset=0 SHALL asynchronously force SM_ARB, phase_cnt all 0, last_grant=G_NUM_CH-1, ch_ready=0, rot_valid=0, res_ready=0, dout_valid=0, rot_phase=0, dout_ch=0, data registers 0.
REQ-029 Reset deassertion mid-operation SHALL resume in SM_ARB with channel 0 highest priority on the first arbitration.

Verification
REQ-030 Single channel 0, four samples (re=0x000100, im=0x000200), all sinks ready -> rot_phase 0,1,2,3 in order, dout_ch=0, dout_valid 3 cycles after each transfer.
REQ-031 All four ch_valid held high, sinks ready -> grant order 0,1,2,3,0,1 and each channel's rot_phase advances by one per its own grant only.
REQ-032 rot_ready held low 5 cycles in SM_ISSUE -> rot_valid/rot_re/rot_phase stable; no ch_ready asserted; completes on first rot_ready cycle.
REQ-033 dout_ready low 3 cycles with res_valid pulsing -> dout data stable, res_ready=0, extra res_valid ignored.
REQ-034 phase_clr[2] coincident with channel 2 transfer at phase_cnt=3 -> rot_phase=3 issued, next channel-2 issue rot_phase=0.
REQ-035 reset=0 asserted asynchronously in SM_WAIT, then enable=0 pulse in SM_SEND in a second run -> all valids/readies 0 immediately (reset) or next edge (enable); next grant starts at channel 0, phase 0.

Source files
------------

// File: rtl/rotator_scheduler_if.sv
// Handshake bundle between rotator_scheduler, its requesting channels, the shared rotator
// and the tagged-result sink.
interface rotator_scheduler_if #(
    parameter int unsigned G_DWIDTH  = 24,
    parameter int unsigned G_NUM_CH  = 4,
    parameter int unsigned G_CH_BITS = $clog2(G_NUM_CH)
);
    // Channel request side
    logic [G_NUM_CH*G_DWIDTH-1:0] ch_re;
    logic [G_NUM_CH*G_DWIDTH-1:0] ch_im;
    logic [G_NUM_CH-1:0]          ch_valid;
    logic [G_NUM_CH-1:0]          ch_ready;

    // Rotator issue side
    logic [G_DWIDTH-1:0]          rot_re;
    logic [G_DWIDTH-1:0]          rot_im;
    logic [1:0]                   rot_phase;
    logic                         rot_valid;
    logic                         rot_ready;

    // Rotator result side
    logic [G_DWIDTH-1:0]          res_re;
    logic [G_DWIDTH-1:0]          res_im;
    logic                         res_valid;
    logic                         res_ready;

    // Tagged output side
    logic [G_DWIDTH-1:0]          dout_re;
    logic [G_DWIDTH-1:0]          dout_im;
    logic [G_CH_BITS-1:0]         dout_ch;
    logic                         dout_valid;
    logic                         dout_ready;

    modport master (
        input  ch_re, ch_im, ch_valid,
        output ch_ready,
        output rot_re, rot_im, rot_phase, rot_valid,
        input  rot_ready,
        input  res_re, res_im, res_valid,
        output res_ready,
        output dout_re, dout_im, dout_ch, dout_valid,
        input  dout_ready
    );

    modport slave (
        output ch_re, ch_im, ch_valid,
        input  ch_ready,
        input  rot_re, rot_im, rot_phase, rot_valid,
        output rot_ready,
        output res_re, res_im, res_valid,
        input  res_ready,
        input  dout_re, dout_im, dout_ch, dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/rotator_scheduler.sv
// Round-robin scheduler sharing one quarter-turn rotator among G_NUM_CH channels, with a
// per-channel phase counter and a single transaction in flight.
module rotator_scheduler #(
    parameter int unsigned G_DWIDTH  = 24,
    parameter int unsigned G_NUM_CH  = 4,
    parameter int unsigned G_CH_BITS = $clog2(G_NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [G_NUM_CH-1:0] phase_clr,
    rotator_scheduler_if.master bus
);

    typedef enum logic [1:0] {SM_ARB, SM_ISSUE, SM_WAIT, SM_SEND} state_e;

    localparam logic [G_CH_BITS-1:0] LastCh = G_CH_BITS'(G_NUM_CH - 1);

    state_e                     state_q, state_d;
    logic [G_NUM_CH-1:0][1:0]   phase_q, phase_d;
    logic [G_CH_BITS-1:0]       last_grant_q, last_grant_d;
    logic [G_CH_BITS-1:0]       grant_q, grant_d;
    logic [G_DWIDTH-1:0]        cap_re_q, cap_re_d;
    logic [G_DWIDTH-1:0]        cap_im_q, cap_im_d;
    logic [1:0]                 cap_ph_q, cap_ph_d;
    logic [G_DWIDTH-1:0]        res_re_q, res_re_d;
    logic [G_DWIDTH-1:0]        res_im_q, res_im_d;

    logic                       win_found;
    logic [G_CH_BITS-1:0]       win_idx;
    int                         cand;
    logic                       transfer;
    logic [G_DWIDTH-1:0]        sel_re;
    logic [G_DWIDTH-1:0]        sel_im;
    logic [1:0]                 sel_ph;

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= int'(G_NUM_CH); k++) begin
            cand = (int'(last_grant_q) + k) % int'(G_NUM_CH);
            if (!win_found && bus.ch_valid[cand[G_CH_BITS-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[G_CH_BITS-1:0];
            end
        end
    end

    // Reset and enable gate ch_ready directly so no grant is offered while either is active.
    assign transfer     = (state_q == SM_ARB) && enable && reset && win_found;
    assign bus.ch_ready = transfer ? (G_NUM_CH'(1) << win_idx) : '0;

    always_comb begin
        sel_re = '0;
        sel_im = '0;
        sel_ph = '0;
        for (int i = 0; i < int'(G_NUM_CH); i++) begin
            if (win_idx == G_CH_BITS'(i)) begin
                sel_re = bus.ch_re[i*G_DWIDTH +: G_DWIDTH];
                sel_im = bus.ch_im[i*G_DWIDTH +: G_DWIDTH];
                sel_ph = phase_q[i];
            end
        end
    end

    // Clear beats increment when coincident with a transfer on the same channel.
    always_comb begin
        phase_d = phase_q;
        for (int i = 0; i < int'(G_NUM_CH); i++) begin
            if (!enable || phase_clr[i]) begin
                phase_d[i] = 2'd0;
            end else if (transfer && (win_idx == G_CH_BITS'(i))) begin
                phase_d[i] = phase_q[i] + 2'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cap_re_d     = cap_re_q;
        cap_im_d     = cap_im_q;
        cap_ph_d     = cap_ph_q;
        res_re_d     = res_re_q;
        res_im_d     = res_im_q;

        if (!enable) begin
            state_d      = SM_ARB;
            last_grant_d = LastCh;
        end else begin
            unique case (state_q)
                SM_ARB: begin
                    if (transfer) begin
                        state_d  = SM_ISSUE;
                        grant_d  = win_idx;
                        cap_re_d = sel_re;
                        cap_im_d = sel_im;
                        cap_ph_d = sel_ph;
                    end
                end
                SM_ISSUE: begin
                    if (bus.rot_ready) begin
                        state_d = SM_WAIT;
                    end
                end
                SM_WAIT: begin
                    if (bus.res_valid) begin
                        state_d  = SM_SEND;
                        res_re_d = bus.res_re;
                        res_im_d = bus.res_im;
                    end
                end
                SM_SEND: begin
                    if (bus.dout_ready) begin
                        state_d      = SM_ARB;
                        last_grant_d = grant_q;
                    end
                end
                default: state_d = SM_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SM_ARB;
            phase_q      <= '0;
            last_grant_q <= LastCh;
            grant_q      <= '0;
            cap_re_q     <= '0;
            cap_im_q     <= '0;
            cap_ph_q     <= '0;
            res_re_q     <= '0;
            res_im_q     <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cap_re_q     <= cap_re_d;
            cap_im_q     <= cap_im_d;
            cap_ph_q     <= cap_ph_d;
            res_re_q     <= res_re_d;
            res_im_q     <= res_im_d;
        end
    end

    assign bus.rot_valid  = (state_q == SM_ISSUE);
    assign bus.rot_re     = cap_re_q;
    assign bus.rot_im     = cap_im_q;
    assign bus.rot_phase  = cap_ph_q;
    assign bus.res_ready  = (state_q == SM_WAIT);
    assign bus.dout_valid = (state_q == SM_SEND);
    assign bus.dout_re    = res_re_q;
    assign bus.dout_im    = res_im_q;
    assign bus.dout_ch    = grant_q;

endmodule

// File: tb/tb_rotator_scheduler.sv
// Directed bench for rotator_scheduler: per-cycle vector table for the steady-state
// schedules, hand-written sequences for stalls, clears, reset and enable flushes.
module tb_rotator_scheduler;

    localparam logic [23:0] RES_RE = 24'h0ABCDE;
    localparam logic [23:0] RES_IM = 24'h012345;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] phase_clr;

    always #5 clk = ~clk;

    rotator_scheduler_if bus ();

    rotator_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .phase_clr (phase_clr),
        .bus       (bus)
    );

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] clr;
        logic [3:0] e_chrdy;
        logic       e_rotv;
        logic       e_resr;
        logic       e_doutv;
        logic [1:0] e_ph;
        logic [1:0] e_ch;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic en, input logic [3:0] valid, input logic [3:0] clr,
                       input logic [3:0] e_chrdy, input logic e_rotv, input logic e_resr,
                       input logic e_doutv, input logic [1:0] e_ph, input logic [1:0] e_ch);
        vec_t v;
        v.en = en; v.valid = valid; v.clr = clr; v.e_chrdy = e_chrdy;
        v.e_rotv = e_rotv; v.e_resr = e_resr; v.e_doutv = e_doutv;
        v.e_ph = e_ph; v.e_ch = e_ch;
        tbl.push_back(v);
    endtask

    // One full transaction with all sinks ready: ARB, ISSUE, WAIT, SEND.
    task automatic add_grant(input int g, input int ph, input logic [3:0] vmask,
                             input logic clr_arb);
        logic [3:0] oh;
        logic [1:0] gc;
        logic [1:0] pc;
        oh = 4'(1 << g);
        gc = 2'(g);
        pc = 2'(ph);
        add(1'b1, vmask, clr_arb ? oh : 4'b0, oh, 1'b0, 1'b0, 1'b0, 2'd0, gc);
        add(1'b1, vmask, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, pc, gc);
        add(1'b1, vmask, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 2'd0, gc);
        add(1'b1, vmask, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 2'd0, gc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single channel 0, four samples: phases 0..3.
        for (int p = 0; p < 4; p++) add_grant(0, p, 4'b0001, 1'b0);
        // Flush: clears phases, last grant back to channel 3.
        add(1'b0, 4'b0000, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        // All channels requesting: 0,1,2,3,0,1 with per-channel phase.
        add_grant(0, 0, 4'b1111, 1'b0);
        add_grant(1, 0, 4'b1111, 1'b0);
        add_grant(2, 0, 4'b1111, 1'b0);
        add_grant(3, 0, 4'b1111, 1'b0);
        add_grant(0, 1, 4'b1111, 1'b0);
        add_grant(1, 1, 4'b1111, 1'b0);
        // Channel 2 alone: clear coincident with transfer at phase 3 and at phase 1.
        add_grant(2, 1, 4'b0100, 1'b0);
        add_grant(2, 2, 4'b0100, 1'b0);
        add_grant(2, 3, 4'b0100, 1'b1);
        add_grant(2, 0, 4'b0100, 1'b0);
        add_grant(2, 1, 4'b0100, 1'b1);
        add_grant(2, 0, 4'b0100, 1'b0);

        reset          = 1'b0;
        enable         = 1'b1;
        phase_clr      = 4'b0;
        bus.ch_valid   = 4'b1111;
        bus.rot_ready  = 1'b1;
        bus.res_valid  = 1'b1;
        bus.dout_ready = 1'b1;
        bus.res_re     = RES_RE;
        bus.res_im     = RES_IM;
        for (int i = 0; i < 4; i++) begin
            bus.ch_re[i*24 +: 24] = 24'(32'h000100 + i);
            bus.ch_im[i*24 +: 24] = 24'(32'h000200 + i);
        end

        #12;
        chk("rst ch_ready", bus.ch_ready, 4'b0);
        chk("rst rot_valid", bus.rot_valid, 1'b0);
        chk("rst res_ready", bus.res_ready, 1'b0);
        chk("rst dout_valid", bus.dout_valid, 1'b0);
        chk("rst rot_phase", bus.rot_phase, 2'd0);
        chk("rst dout_ch", bus.dout_ch, 2'd0);
        chk("rst rot_re", bus.rot_re, 24'd0);
        chk("rst dout_re", bus.dout_re, 24'd0);
        bus.ch_valid = 4'b0;
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[n]) begin
            step();
            enable       = tbl[n].en;
            bus.ch_valid = tbl[n].valid;
            phase_clr    = tbl[n].clr;
            @(negedge clk);
            chk($sformatf("v%0d ch_ready", n), bus.ch_ready, tbl[n].e_chrdy);
            chk($sformatf("v%0d rot_valid", n), bus.rot_valid, tbl[n].e_rotv);
            chk($sformatf("v%0d res_ready", n), bus.res_ready, tbl[n].e_resr);
            chk($sformatf("v%0d dout_valid", n), bus.dout_valid, tbl[n].e_doutv);
            if (tbl[n].e_rotv) begin
                chk($sformatf("v%0d rot_phase", n), bus.rot_phase, tbl[n].e_ph);
                chk($sformatf("v%0d rot_re", n), bus.rot_re, 24'(32'h100 + tbl[n].e_ch));
                chk($sformatf("v%0d rot_im", n), bus.rot_im, 24'(32'h200 + tbl[n].e_ch));
            end
            if (tbl[n].e_doutv) begin
                chk($sformatf("v%0d dout_ch", n), bus.dout_ch, tbl[n].e_ch);
                chk($sformatf("v%0d dout_re", n), bus.dout_re, RES_RE);
                chk($sformatf("v%0d dout_im", n), bus.dout_im, RES_IM);
            end
        end
        phase_clr = 4'b0;

        // Issue stall: channel 0 (phase 2) held in SM_ISSUE for 5 cycles.
        step();
        bus.ch_valid = 4'b0001; bus.rot_ready = 1'b0;
        bus.res_valid = 1'b0; bus.dout_ready = 1'b0;
        @(negedge clk);
        chk("stall grant", bus.ch_ready, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("stall%0d rot_valid", i), bus.rot_valid, 1'b1);
            chk($sformatf("stall%0d rot_re", i), bus.rot_re, 24'h000100);
            chk($sformatf("stall%0d rot_im", i), bus.rot_im, 24'h000200);
            chk($sformatf("stall%0d rot_phase", i), bus.rot_phase, 2'd2);
            chk($sformatf("stall%0d ch_ready", i), bus.ch_ready, 4'b0);
        end
        step();
        bus.rot_ready = 1'b1; bus.ch_valid = 4'b0;
        @(negedge clk);
        chk("stall release rot_valid", bus.rot_valid, 1'b1);
        step();
        bus.rot_ready = 1'b0; bus.res_valid = 1'b1;
        bus.res_re = 24'h111111; bus.res_im = 24'h222222;
        @(negedge clk);
        chk("wait res_ready", bus.res_ready, 1'b1);
        chk("wait rot_valid", bus.rot_valid, 1'b0);

        // Output stall with spurious res_valid pulses.
        for (int i = 0; i < 3; i++) begin
            step();
            bus.res_valid = (i != 1);
            bus.res_re = 24'h333333; bus.res_im = 24'h444444;
            @(negedge clk);
            chk($sformatf("hold%0d dout_valid", i), bus.dout_valid, 1'b1);
            chk($sformatf("hold%0d dout_re", i), bus.dout_re, 24'h111111);
            chk($sformatf("hold%0d dout_im", i), bus.dout_im, 24'h222222);
            chk($sformatf("hold%0d dout_ch", i), bus.dout_ch, 2'd0);
            chk($sformatf("hold%0d res_ready", i), bus.res_ready, 1'b0);
        end
        step();
        bus.dout_ready = 1'b1; bus.res_valid = 1'b0;
        @(negedge clk);
        chk("hold release dout_valid", bus.dout_valid, 1'b1);

        // First run: channel 1 (phase 2), async reset while waiting for the result.
        step();
        bus.ch_valid = 4'b0010; bus.rot_ready = 1'b1; bus.dout_ready = 1'b0;
        @(negedge clk);
        chk("run1 grant", bus.ch_ready, 4'b0010);
        step();
        bus.ch_valid = 4'b0;
        @(negedge clk);
        chk("run1 rot_valid", bus.rot_valid, 1'b1);
        chk("run1 rot_phase", bus.rot_phase, 2'd2);
        step();
        bus.ch_valid = 4'b1111;
        @(negedge clk);
        chk("run1 res_ready", bus.res_ready, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst res_ready", bus.res_ready, 1'b0);
        chk("async rst rot_valid", bus.rot_valid, 1'b0);
        chk("async rst dout_valid", bus.dout_valid, 1'b0);
        chk("async rst ch_ready", bus.ch_ready, 4'b0);
        chk("async rst rot_phase", bus.rot_phase, 2'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.res_valid = 1'b1; bus.dout_ready = 1'b1;
        bus.res_re = RES_RE; bus.res_im = RES_IM;
        #1;
        chk("run2 first grant", bus.ch_ready, 4'b0001);

        // Second run: ch0 completes, ch1 flushed by enable in SM_SEND.
        step(); @(negedge clk);
        chk("run2 ch0 rot_phase", bus.rot_phase, 2'd0);
        chk("run2 ch0 rot_re", bus.rot_re, 24'h000100);
        step(); @(negedge clk);
        chk("run2 ch0 res_ready", bus.res_ready, 1'b1);
        step(); @(negedge clk);
        chk("run2 ch0 dout_valid", bus.dout_valid, 1'b1);
        chk("run2 ch0 dout_ch", bus.dout_ch, 2'd0);
        step(); @(negedge clk);
        chk("run2 ch1 grant", bus.ch_ready, 4'b0010);
        step(); @(negedge clk);
        chk("run2 ch1 rot_phase", bus.rot_phase, 2'd0);
        chk("run2 ch1 rot_re", bus.rot_re, 24'h000101);
        step(); @(negedge clk);
        chk("run2 ch1 res_ready", bus.res_ready, 1'b1);
        step();
        enable = 1'b0; bus.dout_ready = 1'b0;
        @(negedge clk);
        chk("flush edge dout_valid", bus.dout_valid, 1'b1);
        chk("flush edge dout_ch", bus.dout_ch, 2'd1);
        step(); @(negedge clk);
        chk("flush dout_valid", bus.dout_valid, 1'b0);
        chk("flush ch_ready", bus.ch_ready, 4'b0);
        chk("flush rot_valid", bus.rot_valid, 1'b0);
        chk("flush res_ready", bus.res_ready, 1'b0);
        step();
        enable = 1'b1; bus.dout_ready = 1'b1;
        @(negedge clk);
        chk("post-flush grant", bus.ch_ready, 4'b0001);
        step();
        bus.ch_valid = 4'b0;
        @(negedge clk);
        chk("post-flush rot_valid", bus.rot_valid, 1'b1);
        chk("post-flush rot_phase", bus.rot_phase, 2'd0);
        chk("post-flush rot_re", bus.rot_re, 24'h000100);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
